gpio_in: RTL and testbench
==========================

# gpio_in

Input-side GPIO peripheral for the MIPS32 SoC: receives external GPIO pins driven by the board or a stimulus bench, synchronises and debounces each bit, and latches rising and falling edge events into status registers. The CPU reads it over the SoC's single-cycle register bus. It raises a level interrupt toward the CPU interrupt lines when an enabled event is pending. It is the reader counterpart to the SoC's GPIO output port.

## Interface
- GPIO_W, 8: number of input pins, 1..32
- DB_CYCLES, 4: consecutive stable cycles required before the debounced value changes; minimum 1 (1 = no filtering beyond synchroniser)
- CNT_W, 16: debounce counter width; must satisfy DB_CYCLES <= 2^CNT_W

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- gpio_i  in  GPIO_W  raw external pins, asynchronous to clk
- cs  in  1  register select, one-cycle strobe per access
- we  in  1  1 = write, 0 = read (qualified by cs)
- addr  in  2  register index (word address bits [3:2])
- wdata  in  32  write data
- rdata  out  32  read data, valid when ack=1
- ack  out  1  access complete, one cycle after cs
- irq  out  1  level interrupt, registered

## Operation
- Per bit: 2-flop synchroniser (s1, s2), then debounce counter cnt[i] and debounced value db[i].
- Debounce, per bit, each edge: if s2==db then cnt<=0; else if cnt==DB_CYCLES-1 then db<=s2, cnt<=0; else cnt<=cnt+1. Any glitch back to db restarts the count.
- Event: on the edge where db[i] flips 0->1, set rise[i]; on 1->0, set fall[i]. Status is sticky until cleared.
- Registers (addr):
  - 0 DATA: RO, db zero-extended to 32 bits; writes ignored
  - 1 RISE: rise status, write-1-to-clear
  - 2 FALL: fall status, write-1-to-clear
  - 3 IEN: RW interrupt enable, bits [2*GPIO_W-1:0]; low half enables rise, high half enables fall. Bits above are read 0 and writes are ignored.
- irq <= |((rise & ien_rise) | (fall & ien_fall)), registered each edge.
- Simultaneous W1C and new event on the same bit in the same cycle: set wins; the bit stays 1.
- Writing 0 bits to RISE/FALL leaves those bits unchanged.
- Reset: s1, s2, db, cnt, rise, fall, ien, irq, ack and rdata all 0. A pin held high through reset produces a rise event after release; this is intended.
- Reset asserted mid-debounce or mid-access: everything returns to reset values immediately. A pending ack is dropped.

## Timing
- Pin change sampled at edge E: s2 updates at E+1, db flips at E+1+DB_CYCLES, status bit set at that same edge, irq at the following edge.
  - DB_CYCLES=4: db at E+5, irq at E+6.
- Pulses shorter than DB_CYCLES cycles as seen at s2 are rejected.
- Bus: cs sampled at edge N; writes take effect at N; ack=1 and rdata valid during cycle N..N+1, with ack for exactly one cycle.
- A read returns the register value before any update at edge N. Back-to-back cs every cycle is supported, one ack per access.
- A W1C write clearing the last pending enabled bit drops irq one edge later.

## Test plan
- Reset: hold rst=0 with gpio_i=8'hFF, cs toggling -> rdata=0, ack=0, irq=0. Release rst -> DATA reads 8'hFF after 5 cycles (DB_CYCLES=4). RISE=8'hFF.
- Glitch reject: bit0 high for 3 cycles, then low -> DATA bit0 stays 0, RISE=0, irq=0.
- Edge and irq: write IEN=16'h0001, then drive bit0 high steadily -> DATA=1 and RISE=1 at E+5, irq=1 at E+6. Write RISE=1 -> RISE=0, irq=0 one edge after the write.
- Fall path: IEN=16'h0100, bit0 1->0 -> FALL=1, irq=1. Writing FALL=0 leaves FALL=1.
- Collision: issue W1C of RISE bit3 on the same edge bit3's db flips 0->1 -> RISE bit3 reads 1 afterwards.
- Back-to-back: cs=1 for 4 consecutive reads of addr 0..3 -> 4 acks on consecutive cycles with the correct data. Assert rst mid-sequence -> ack=0 immediately.

Source files
------------

// File: rtl/gpio_in.sv
// gpio_in: synchronised, debounced GPIO input port with sticky edge status and a level interrupt.
// Ports: clk; rst (async, active-low); gpio_i raw pins; cs/we/addr/wdata single-cycle register bus;
//        rdata/ack read response one cycle after cs; irq registered level interrupt.
// Registers: 0 DATA (RO debounced pins), 1 RISE (W1C), 2 FALL (W1C), 3 IEN (rise enables low half, fall enables high half).
module gpio_in #(
    parameter int GPIO_W    = 8,
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GPIO_W-1:0] gpio_i,
    input  logic              cs,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              irq
);
    localparam int IEN_W = 2 * GPIO_W;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    logic [GPIO_W-1:0] s1, s2, db, db_nxt, rise, fall, rise_clr, fall_clr;
    logic [CNT_W-1:0]  cnt [GPIO_W];
    logic [CNT_W-1:0]  cnt_nxt [GPIO_W];
    logic [IEN_W-1:0]  ien;
    logic [31:0]       rd;
    logic              wr;
    // Any sample equal to db restarts the count, so only an unbroken run of DB_CYCLES flips db.
    always_comb begin
        for (int i = 0; i < GPIO_W; i++) begin
            cnt_nxt[i] = (s2[i] == db[i] || cnt[i] == DB_LAST) ? '0 : cnt[i] + 1'b1;
            db_nxt[i]  = (s2[i] != db[i] && cnt[i] == DB_LAST) ? s2[i] : db[i];
        end
    end
    assign wr       = cs && we;
    assign rise_clr = (wr && addr == 2'd1) ? wdata[GPIO_W-1:0] : '0;
    assign fall_clr = (wr && addr == 2'd2) ? wdata[GPIO_W-1:0] : '0;
    assign rd = (addr == 2'd0) ? 32'(db) :
                (addr == 2'd1) ? 32'(rise) :
                (addr == 2'd2) ? 32'(fall) : 32'(ien);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= '0;
            s2    <= '0;
            db    <= '0;
            rise  <= '0;
            fall  <= '0;
            ien   <= '0;
            irq   <= 1'b0;
            ack   <= 1'b0;
            rdata <= '0;
            for (int i = 0; i < GPIO_W; i++) cnt[i] <= '0;
        end else begin
            s1    <= gpio_i;
            s2    <= s1;
            db    <= db_nxt;
            for (int i = 0; i < GPIO_W; i++) cnt[i] <= cnt_nxt[i];
            // A new event on a bit wins over a simultaneous clear of that bit.
            rise  <= (rise & ~rise_clr) | (db_nxt & ~db);
            fall  <= (fall & ~fall_clr) | (~db_nxt & db);
            if (wr && addr == 2'd3) ien <= IEN_W'({32'd0, wdata});
            irq   <= |((rise & ien[GPIO_W-1:0]) | (fall & ien[IEN_W-1:GPIO_W]));
            ack   <= cs;
            rdata <= (cs && !we) ? rd : '0;
        end
    end
endmodule

// File: tb/tb_gpio_in.sv
// tb_gpio_in: directed self-checking bench for gpio_in (GPIO_W=8, DB_CYCLES=4).
module tb_gpio_in;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  gpio_i;
    logic        cs, we;
    logic [1:0]  addr;
    logic [31:0] wdata, rdata, d;
    logic        ack, irq;
    int          checks = 0;
    int          errs = 0;
    logic [31:0] bb [4] = '{32'h08, 32'h08, 32'h00, 32'h100};

    gpio_in dut (
        .clk(clk), .rst(rst), .gpio_i(gpio_i), .cs(cs), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ack(ack), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        chk("rd_ack", 32'(ack), 32'd1);
        v = rdata;
        cs = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        cs = 1'b1; we = 1'b1; addr = a; wdata = v;
        @(negedge clk);
        chk("wr_ack", 32'(ack), 32'd1);
        cs = 1'b0; we = 1'b0;
    endtask

    initial begin
        cs = 0; we = 0; addr = 0; wdata = 0; gpio_i = 8'hFF;
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_ack", 32'(ack), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_irq", 32'(irq), 32'd0);
            cs = ~cs;
        end
        @(negedge clk);
        cs = 1'b0; rst = 1'b1;
        repeat (5) @(negedge clk);
        rd(2'd0, d); chk("data_e5", d, 32'h00);
        rd(2'd0, d); chk("data_e6", d, 32'hFF);
        rd(2'd1, d); chk("rise_after_rst", d, 32'hFF);
        chk("irq_ien0", 32'(irq), 32'd0);
        wr(2'd1, 32'hFF);
        gpio_i = 8'h00;
        repeat (10) @(negedge clk);
        wr(2'd2, 32'hFF);
        rd(2'd0, d); chk("data_low", d, 32'h00);
        rd(2'd1, d); chk("rise_clr", d, 32'h00);
        rd(2'd2, d); chk("fall_clr", d, 32'h00);
        gpio_i = 8'h01;
        repeat (3) @(negedge clk);
        gpio_i = 8'h00;
        repeat (10) @(negedge clk);
        rd(2'd0, d); chk("glitch_data", d, 32'h00);
        rd(2'd1, d); chk("glitch_rise", d, 32'h00);
        chk("glitch_irq", 32'(irq), 32'd0);
        wr(2'd3, 32'h0001);
        gpio_i = 8'h01;
        repeat (6) @(negedge clk);
        chk("irq_e5", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_e6", 32'(irq), 32'd1);
        rd(2'd1, d); chk("rise_bit0", d, 32'h01);
        rd(2'd0, d); chk("data_bit0", d, 32'h01);
        wr(2'd1, 32'h01);
        chk("irq_hold", 32'(irq), 32'd1);
        @(negedge clk);
        chk("irq_drop", 32'(irq), 32'd0);
        rd(2'd1, d); chk("rise_w1c", d, 32'h00);
        wr(2'd3, 32'h0100);
        gpio_i = 8'h00;
        repeat (8) @(negedge clk);
        chk("fall_irq", 32'(irq), 32'd1);
        rd(2'd2, d); chk("fall_bit0", d, 32'h01);
        wr(2'd2, 32'h00);
        rd(2'd2, d); chk("fall_w0", d, 32'h01);
        wr(2'd2, 32'h01);
        @(negedge clk);
        chk("fall_irq_drop", 32'(irq), 32'd0);
        gpio_i = 8'h08;
        repeat (5) @(negedge clk);
        wr(2'd1, 32'h08);
        rd(2'd1, d); chk("collision", d, 32'h08);
        wr(2'd3, 32'hFFFFFFFF);
        rd(2'd3, d); chk("ien_mask", d, 32'h0000FFFF);
        wr(2'd3, 32'h0100);
        cs = 1'b1; we = 1'b0; addr = 2'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("b2b_ack", 32'(ack), 32'd1);
            chk("b2b_data", rdata, bb[k]);
            addr = 2'(k + 1);
            if (k == 3) cs = 1'b0;
        end
        @(negedge clk);
        chk("b2b_idle", 32'(ack), 32'd0);
        cs = 1'b1; addr = 2'd0;
        @(negedge clk);
        chk("mid_ack", 32'(ack), 32'd1);
        addr = 2'd1;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        cs = 1'b0; rst = 1'b1;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
